// File: rtl/segasys1_rom_fetch.sv
// Tile/sprite ROM fetch stage for the System 1/2 video block: one-word cache per
// client, both fed from a single shared 32-bit SDRAM read channel (toggle req/ack).
module segasys1_rom_fetch #(
    parameter logic [21:0] TILE_BASE = 22'h040000,
    parameter logic [21:0] SPR_BASE  = 22'h020000
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [14:0] tile_rom_addr,
    output logic [31:0] tile_rom_do,
    input  logic [17:0] spr_rom_addr,
    output logic [7:0]  spr_rom_do,
    output logic [21:0] sd_addr,
    output logic        sd_req,
    input  logic        sd_ack,
    input  logic [31:0] sd_dout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT_T, WAIT_S} state_t;

    state_t      state;
    state_t      state_nx;
    logic        tile_valid;
    logic        spr_valid;
    logic [14:0] tile_tag;
    logic [15:0] spr_tag;
    logic [31:0] spr_word;
    logic        last_spr;
    logic [15:0] pend_addr;
    logic        tile_miss;
    logic        spr_miss;
    logic        issue_t;
    logic        issue_s;
    logic        done;
    logic [21:0] tile_sd_addr;
    logic [21:0] spr_sd_addr;
    logic [7:0]  spr_byte;

    assign tile_miss    = !tile_valid || (tile_rom_addr != tile_tag);
    assign spr_miss     = !spr_valid || (spr_rom_addr[17:2] != spr_tag);
    // 22-bit sums; any carry out of bit 21 wraps around
    assign tile_sd_addr = TILE_BASE + {5'd0, tile_rom_addr, 2'b00};
    assign spr_sd_addr  = SPR_BASE + {4'd0, spr_rom_addr[17:2], 2'b00};

    always_comb begin
        spr_byte = spr_word[7:0];
        case (spr_rom_addr[1:0])
            2'd0: spr_byte = spr_word[7:0];
            2'd1: spr_byte = spr_word[15:8];
            2'd2: spr_byte = spr_word[23:16];
            2'd3: spr_byte = spr_word[31:24];
            default: spr_byte = spr_word[7:0];
        endcase
    end

    // When both clients miss, the one not served last wins so neither starves
    always_comb begin
        state_nx = state;
        issue_t  = 1'b0;
        issue_s  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (tile_miss && spr_miss) begin
                    if (last_spr) issue_t = 1'b1;
                    else          issue_s = 1'b1;
                end else if (tile_miss) begin
                    issue_t = 1'b1;
                end else if (spr_miss) begin
                    issue_s = 1'b1;
                end
                if (issue_t)      state_nx = WAIT_T;
                else if (issue_s) state_nx = WAIT_S;
            end
            WAIT_T, WAIT_S: begin
                if (sd_ack == sd_req) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            tile_rom_do <= '0;
            spr_rom_do  <= '0;
            sd_addr     <= '0;
            sd_req      <= 1'b0;
            busy        <= 1'b0;
            tile_valid  <= 1'b0;
            spr_valid   <= 1'b0;
            tile_tag    <= '0;
            spr_tag     <= '0;
            spr_word    <= '0;
            last_spr    <= 1'b1;
            pend_addr   <= '0;
        end else begin
            if (issue_t) begin
                sd_addr   <= tile_sd_addr;
                pend_addr <= {1'b0, tile_rom_addr};
                sd_req    <= ~sd_req;
                busy      <= 1'b1;
            end
            if (issue_s) begin
                sd_addr   <= spr_sd_addr;
                pend_addr <= spr_rom_addr[17:2];
                sd_req    <= ~sd_req;
                busy      <= 1'b1;
            end
            // Tag takes the address actually fetched; a moved address just misses again
            if (done) begin
                busy <= 1'b0;
                if (state == WAIT_T) begin
                    tile_rom_do <= sd_dout;
                    tile_tag    <= pend_addr[14:0];
                    tile_valid  <= 1'b1;
                    last_spr    <= 1'b0;
                end else begin
                    spr_word  <= sd_dout;
                    spr_tag   <= pend_addr;
                    spr_valid <= 1'b1;
                    last_spr  <= 1'b1;
                end
            end
            if (!spr_miss) spr_rom_do <= spr_byte;
        end
    end

endmodule

// File: tb/tb_segasys1_rom_fetch.sv
// Directed bench for segasys1_rom_fetch: hand-computed fetch addresses, arbitration
// order, cache hits, refetch after address change, reset mid-fetch and address wrap.
module tb_segasys1_rom_fetch;

    logic        clk;
    logic        RESET_N;
    logic [14:0] tile_rom_addr;
    logic [31:0] tile_rom_do;
    logic [17:0] spr_rom_addr;
    logic [7:0]  spr_rom_do;
    logic [21:0] sd_addr;
    logic        sd_req;
    logic        sd_ack;
    logic [31:0] sd_dout;
    logic        busy;

    logic [14:0] tile_rom_addr2;
    logic [31:0] tile_rom_do2;
    logic [17:0] spr_rom_addr2;
    logic [7:0]  spr_rom_do2;
    logic [21:0] sd_addr2;
    logic        sd_req2;
    logic        sd_ack2;
    logic [31:0] sd_dout2;
    logic        busy2;

    int   checks;
    int   failures;
    logic expReq;

    segasys1_rom_fetch dut (
        .clk(clk), .RESET_N(RESET_N),
        .tile_rom_addr(tile_rom_addr), .tile_rom_do(tile_rom_do),
        .spr_rom_addr(spr_rom_addr), .spr_rom_do(spr_rom_do),
        .sd_addr(sd_addr), .sd_req(sd_req), .sd_ack(sd_ack),
        .sd_dout(sd_dout), .busy(busy)
    );

    segasys1_rom_fetch #(.TILE_BASE(22'h3F0000), .SPR_BASE(22'h020000)) dutWrap (
        .clk(clk), .RESET_N(RESET_N),
        .tile_rom_addr(tile_rom_addr2), .tile_rom_do(tile_rom_do2),
        .spr_rom_addr(spr_rom_addr2), .spr_rom_do(spr_rom_do2),
        .sd_addr(sd_addr2), .sd_req(sd_req2), .sd_ack(sd_ack2),
        .sd_dout(sd_dout2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] tileAddr, input logic [17:0] sprAddr);
        tile_rom_addr = tileAddr;
        spr_rom_addr  = sprAddr;
    endtask

    // Called right after the issue tick; completion lands on the latency-th edge.
    task automatic ackFetch(input int latency, input logic [31:0] data);
        repeat (latency - 1) tick();
        sd_dout = data;
        sd_ack  = expReq;
        tick();
    endtask

    task automatic expectIssue(input string tag, input logic [21:0] addr);
        tick();
        expReq = ~expReq;
        checkOutput({tag, "_req"}, {31'd0, sd_req}, {31'd0, expReq});
        checkOutput({tag, "_addr"}, {10'd0, sd_addr}, {10'd0, addr});
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        expReq   = 1'b0;
        RESET_N  = 1'b0;
        sd_ack   = 1'b0;
        sd_dout  = '0;
        applyStimulus(15'd0, 18'd0);
        tile_rom_addr2 = 15'h7FFF;
        spr_rom_addr2  = 18'd0;
        sd_ack2        = 1'b0;
        sd_dout2       = '0;

        tick();
        tick();
        checkOutput("rst_tile_do", tile_rom_do, 32'd0);
        checkOutput("rst_spr_do", {24'd0, spr_rom_do}, 32'd0);
        checkOutput("rst_req", {31'd0, sd_req}, 32'd0);
        checkOutput("rst_addr", {10'd0, sd_addr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        RESET_N = 1'b1;
        expectIssue("first_tile", 22'h040000);
        checkOutput("wrap_addr", {10'd0, sd_addr2}, 32'h0000FFFC);
        checkOutput("wrap_req", {31'd0, sd_req2}, 32'd1);
        ackFetch(3, 32'hDEADBEEF);
        checkOutput("first_tile_do", tile_rom_do, 32'hDEADBEEF);
        checkOutput("first_tile_busy", {31'd0, busy}, 32'd0);
        expectIssue("first_spr", 22'h020000);
        ackFetch(3, 32'h44332211);

        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("spr_byte%0d", i), {24'd0, spr_rom_do}, 32'h11 * (i + 1));
            if (i < 3) spr_rom_addr = 18'(i + 1);
        end
        checkOutput("hit_no_req", {31'd0, sd_req}, {31'd0, expReq});
        checkOutput("hit_no_busy", {31'd0, busy}, 32'd0);

        applyStimulus(15'd10, 18'h100);
        expectIssue("alt1_tile", 22'h040028);
        ackFetch(2, 32'h10101010);
        checkOutput("alt1_tile_do", tile_rom_do, 32'h10101010);
        tile_rom_addr = 15'h20;
        expectIssue("alt2_spr", 22'h020100);
        ackFetch(2, 32'h20202020);
        spr_rom_addr = 18'h205;
        expectIssue("alt3_tile", 22'h040080);
        ackFetch(2, 32'h30303030);
        checkOutput("alt3_tile_do", tile_rom_do, 32'h30303030);
        tile_rom_addr = 15'h22;
        expectIssue("alt4_spr", 22'h020204);
        ackFetch(2, 32'hA1B2C3D4);
        checkOutput("spr_hold_on_miss", {24'd0, spr_rom_do}, 32'h44);

        tile_rom_addr = 15'd5;
        expectIssue("tile5", 22'h040014);
        checkOutput("spr_after_fill", {24'd0, spr_rom_do}, 32'hC3);
        tile_rom_addr = 15'd6;
        ackFetch(3, 32'h55555555);
        checkOutput("tile5_do", tile_rom_do, 32'h55555555);
        expectIssue("tile6_refetch", 22'h040018);
        ackFetch(2, 32'h66666666);
        checkOutput("tile6_do", tile_rom_do, 32'h66666666);

        spr_rom_addr = 18'h3000;
        expectIssue("spr_pre_reset", 22'h023000);
        tick();
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_tile_do", tile_rom_do, 32'd0);
        checkOutput("mid_rst_spr_do", {24'd0, spr_rom_do}, 32'd0);
        checkOutput("mid_rst_req", {31'd0, sd_req}, 32'd0);
        checkOutput("mid_rst_addr", {10'd0, sd_addr}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        sd_ack  = expReq;
        sd_dout = 32'hFFFFFFFF;
        tick();
        checkOutput("late_ack_tile_do", tile_rom_do, 32'd0);
        checkOutput("late_ack_busy", {31'd0, busy}, 32'd0);
        sd_ack  = 1'b0;
        expReq  = 1'b0;
        RESET_N = 1'b1;
        expectIssue("post_rst_tile", 22'h040018);
        checkOutput("post_rst_tile_do", tile_rom_do, 32'd0);
        ackFetch(2, 32'h77777777);
        checkOutput("post_rst_tile_fill", tile_rom_do, 32'h77777777);
        expectIssue("post_rst_spr", 22'h023000);
        ackFetch(2, 32'h89ABCDEF);
        tick();
        checkOutput("post_rst_spr_do", {24'd0, spr_rom_do}, 32'hEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
